// File: rtl/alu_result_fifo_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_fifo_pkg
//   Shared definitions for the ALU result FIFO: unit ID encoding (the same
//   encoding the ALU decoder uses), the tag that travels with every stored
//   result, and a helper that derives the full entry width.
// -----------------------------------------------------------------------------
package alu_result_fifo_pkg;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'd0,
        UNIT_LOGIC = 2'd1,
        UNIT_CMP   = 2'd2,
        UNIT_SHIFT = 2'd3
    } unit_id_e;

    // Tag stored above the result bits: {unit, carry}
    typedef struct packed {
        unit_id_e unit;
        logic     carry;
    } entry_tag_t;

    localparam int ENTRY_TAG_W = $bits(entry_tag_t);

    // Stored entry = {entry_tag_t, result}, i.e. RES_WIDTH + 3 bits
    function automatic int entry_width(input int res_width);
        return res_width + ENTRY_TAG_W;
    endfunction

endpackage

// File: rtl/alu_result_fifo_result_select.sv
// -----------------------------------------------------------------------------
// result_select
//   Combinational fixed-priority selector (Arith > Logic > CMP > Shift).
//   Produces the tagged entry for the highest-priority flagged unit, a push
//   request when any flag is high, and a multi_flag indication when more than
//   one flag is high in the same cycle.
//
// Ports
//   arith_out/logic_out/cmp_out/shift_out  in   unit results
//   carry_out                              in   carry, used only for arith
//   arith_flag/logic_flag/cmp_flag/shift_flag in unit result valid
//   entry                                  out  {unit, carry, result}
//   push                                   out  any flag high
//   multi_flag                             out  two or more flags high
// -----------------------------------------------------------------------------
module result_select
    import alu_result_fifo_pkg::*;
#(
    parameter int RES_WIDTH = 32
) (
    input  logic [RES_WIDTH-1:0]             arith_out,
    input  logic [RES_WIDTH-1:0]             logic_out,
    input  logic [RES_WIDTH-1:0]             cmp_out,
    input  logic [RES_WIDTH-1:0]             shift_out,
    input  logic                             carry_out,
    input  logic                             arith_flag,
    input  logic                             logic_flag,
    input  logic                             cmp_flag,
    input  logic                             shift_flag,
    output logic [RES_WIDTH+ENTRY_TAG_W-1:0] entry,
    output logic                             push,
    output logic                             multi_flag
);

    entry_tag_t           sel_tag;
    logic [RES_WIDTH-1:0] sel_data;

    always_comb begin
        sel_tag  = '{unit: UNIT_ARITH, carry: 1'b0};
        sel_data = '0;
        if (arith_flag) begin
            sel_tag.unit  = UNIT_ARITH;
            sel_tag.carry = carry_out;
            sel_data      = arith_out;
        end else if (logic_flag) begin
            sel_tag.unit  = UNIT_LOGIC;
            sel_data      = logic_out;
        end else if (cmp_flag) begin
            sel_tag.unit  = UNIT_CMP;
            sel_data      = cmp_out;
        end else if (shift_flag) begin
            sel_tag.unit  = UNIT_SHIFT;
            sel_data      = shift_out;
        end
    end

    assign entry      = {sel_tag, sel_data};
    assign push       = arith_flag | logic_flag | cmp_flag | shift_flag;
    assign multi_flag = (arith_flag & logic_flag) | (arith_flag & cmp_flag)
                      | (arith_flag & shift_flag) | (logic_flag & cmp_flag)
                      | (logic_flag & shift_flag) | (cmp_flag & shift_flag);

endmodule

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Collects the registered ALU unit outputs, tags the selected result with
//   its unit ID and carry, and queues it for a valid/ready consumer. Drops on
//   a full FIFO and multi-flag cycles are reported as sticky status.
//
// Ports
//   CLK, rst                 clock (rising edge), async active-low reset
//   *_OUT, Carry_OUT, *_Flag unit results, carry and valid flags
//   out_valid/out_ready      head handshake
//   out_data/unit/carry      head entry fields (0 while empty)
//   fifo_level               occupancy, 0..DEPTH
//   overflow, multi_flag_err sticky status
//   drop_count               saturating dropped-push counter
//   status_clr               synchronous clear of the three status outputs
// -----------------------------------------------------------------------------
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int RES_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [RES_WIDTH-1:0]     Arith_OUT,
    input  logic [RES_WIDTH-1:0]     Logic_OUT,
    input  logic [RES_WIDTH-1:0]     CMP_OUT,
    input  logic [RES_WIDTH-1:0]     Shift_OUT,
    input  logic                     Carry_OUT,
    input  logic                     Arith_Flag,
    input  logic                     Logic_Flag,
    input  logic                     CMP_Flag,
    input  logic                     Shift_Flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_WIDTH-1:0]     out_data,
    output logic [1:0]               out_unit,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     multi_flag_err,
    output logic [CNT_WIDTH-1:0]     drop_count,
    input  logic                     status_clr
);

    localparam int ENTRY_W = entry_width(RES_WIDTH);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [ENTRY_W-1:0]   sel_entry;
    logic                 sel_push;
    logic                 sel_multi;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 multi_err_q, multi_err_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;
    logic [ENTRY_W-1:0]   head;
    entry_tag_t           head_tag;

    result_select #(
        .RES_WIDTH (RES_WIDTH)
    ) u_result_select (
        .arith_out  (Arith_OUT),
        .logic_out  (Logic_OUT),
        .cmp_out    (CMP_OUT),
        .shift_out  (Shift_OUT),
        .carry_out  (Carry_OUT),
        .arith_flag (Arith_Flag),
        .logic_flag (Logic_Flag),
        .cmp_flag   (CMP_Flag),
        .shift_flag (Shift_Flag),
        .entry      (sel_entry),
        .push       (sel_push),
        .multi_flag (sel_multi)
    );

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LVL_FULL);
    assign pop       = out_valid & out_ready;
    // A pop on a full FIFO frees the slot the push lands in on the same edge.
    assign push_ok   = sel_push & (~full | pop);
    assign drop      = sel_push & full & ~pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        multi_err_d = multi_err_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new event in the clear cycle wins over the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (status_clr) begin
                drop_cnt_d = CNT_WIDTH'(1);
            end else if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end else if (status_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        if (sel_multi) begin
            multi_err_d = 1'b1;
        end else if (status_clr) begin
            multi_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            multi_err_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            multi_err_q <= multi_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is not reset; the output gating below hides stale contents.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= sel_entry;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign head_tag = entry_tag_t'(head[ENTRY_W-1:RES_WIDTH]);

    assign out_data       = out_valid ? head[RES_WIDTH-1:0] : '0;
    assign out_unit       = out_valid ? head_tag.unit : 2'b00;
    assign out_carry      = out_valid & head_tag.carry;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;
    assign multi_flag_err = multi_err_q;
    assign drop_count     = drop_cnt_q;

endmodule
